// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone RW arbiter.
// wb_req_t is the master request record at the default bus width.
package wb_arb_pkg;

    localparam int WB_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                 cyc;
        logic                 stb;
        logic                 we;
        logic [WB_XLEN-1:0]   addr;
        logic [WB_XLEN-1:0]   data;
        logic [WB_XLEN/8-1:0] sel;
    } wb_req_t;

    // One extra bit so the counter can hold MAX_OUTSTANDING itself.
    function automatic int cnt_width(input int max_out);
        return $clog2(max_out) + 1;
    endfunction

endpackage

// File: rtl/wb_arb_outstanding.sv
// Outstanding-request counter for one granted Wishbone cycle.
// A response with nothing in flight is ignored so the count never wraps.
module wb_arb_outstanding
    import wb_arb_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_issue,
    input  logic i_resp,
    output logic o_full,
    output logic o_empty
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resp_ok;

    assign o_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign o_empty = (cnt_q == '0);
    assign resp_ok = i_resp & ~o_empty;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_issue && !resp_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!i_issue && resp_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_rw_arbiter.sv
// Two-master pipelined Wishbone arbiter in front of the memory_system RW port.
// Define WB_RW_ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed priority to master 0.
//
// state | meaning
// IDLE  | no owner, slave CYC low, both masters stalled, arbitrate on CYC
// OWN0  | master 0 owns the bus until it drops CYC
// OWN1  | master 1 owns the bus until it drops CYC
module wb_rw_arbiter
    import wb_arb_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,

    input  logic              i_m0_cyc,
    input  logic              i_m0_stb,
    input  logic              i_m0_we,
    input  logic [XLEN-1:0]   i_m0_addr,
    input  logic [XLEN-1:0]   i_m0_data,
    input  logic [XLEN/8-1:0] i_m0_sel,
    output logic [XLEN-1:0]   o_m0_data,
    output logic              o_m0_ack,
    output logic              o_m0_stall,
    output logic              o_m0_err,

    input  logic              i_m1_cyc,
    input  logic              i_m1_stb,
    input  logic              i_m1_we,
    input  logic [XLEN-1:0]   i_m1_addr,
    input  logic [XLEN-1:0]   i_m1_data,
    input  logic [XLEN/8-1:0] i_m1_sel,
    output logic [XLEN-1:0]   o_m1_data,
    output logic              o_m1_ack,
    output logic              o_m1_stall,
    output logic              o_m1_err,

    output logic              o_s_cyc,
    output logic              o_s_stb,
    output logic              o_s_we,
    output logic [XLEN-1:0]   o_s_addr,
    output logic [XLEN-1:0]   o_s_data,
    output logic [XLEN/8-1:0] o_s_sel,
    input  logic [XLEN-1:0]   i_s_data,
    input  logic              i_s_ack,
    input  logic              i_s_stall,
    input  logic              i_s_err
);

    arb_state_t state_q, state_d;
    logic       abort_q, abort_d;
    logic       own0, own1, owned;
    logic       req_stb, full, empty;
    logic       issue, resp, release_own, clear;
    logic       grant0, grant1;

    // Reset gates ownership, which forces every output to its idle value.
    assign own0  = i_reset_n & (state_q == OWN0);
    assign own1  = i_reset_n & (state_q == OWN1);
    assign owned = own0 | own1;

`ifdef WB_RW_ARB_ROUND_ROBIN_EN
    logic last_q;

    assign grant0 = i_m0_cyc & (~i_m1_cyc | last_q);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            last_q <= 1'b1;
        end else if (state_q == IDLE && grant0) begin
            last_q <= 1'b0;
        end else if (state_q == IDLE && grant1) begin
            last_q <= 1'b1;
        end
    end
`else
    assign grant0 = i_m0_cyc;
`endif
    assign grant1 = i_m1_cyc & ~grant0;

    always_comb begin
        o_s_cyc  = 1'b0;
        req_stb  = 1'b0;
        o_s_we   = 1'b0;
        o_s_addr = '0;
        o_s_data = '0;
        o_s_sel  = '0;
        if (own0) begin
            o_s_cyc  = i_m0_cyc;
            req_stb  = i_m0_cyc & i_m0_stb;
            o_s_we   = i_m0_we;
            o_s_addr = i_m0_addr;
            o_s_data = i_m0_data;
            o_s_sel  = i_m0_sel;
        end else if (own1) begin
            o_s_cyc  = i_m1_cyc;
            req_stb  = i_m1_cyc & i_m1_stb;
            o_s_we   = i_m1_we;
            o_s_addr = i_m1_addr;
            o_s_data = i_m1_data;
            o_s_sel  = i_m1_sel;
        end
    end

    assign o_s_stb = req_stb & ~full & ~abort_q;

    assign o_m0_stall = ~own0 | i_s_stall | full | abort_q;
    assign o_m1_stall = ~own1 | i_s_stall | full | abort_q;

    // Responses with nothing in flight are stray and never reach a master.
    assign o_m0_ack  = own0 & i_s_ack & ~empty;
    assign o_m0_err  = own0 & i_s_err & ~empty;
    assign o_m0_data = own0 ? i_s_data : '0;
    assign o_m1_ack  = own1 & i_s_ack & ~empty;
    assign o_m1_err  = own1 & i_s_err & ~empty;
    assign o_m1_data = own1 ? i_s_data : '0;

    assign issue       = o_s_stb & ~i_s_stall;
    assign resp        = owned & (i_s_ack | i_s_err);
    assign release_own = (own0 & ~i_m0_cyc) | (own1 & ~i_m1_cyc);
    assign clear       = ~owned | release_own;

    wb_arb_outstanding #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_outstanding (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_clear  (clear),
        .i_issue  (issue),
        .i_resp   (resp),
        .o_full   (full),
        .o_empty  (empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant0) begin
                    state_d = OWN0;
                end else if (grant1) begin
                    state_d = OWN1;
                end
            end
            OWN0:    if (!i_m0_cyc) state_d = IDLE;
            OWN1:    if (!i_m1_cyc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An error ends the useful part of the cycle; hold off STBs until CYC drops.
    always_comb begin
        abort_d = abort_q;
        if (clear) begin
            abort_d = 1'b0;
        end else if (i_s_err && !empty) begin
            abort_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_wb_rw_arbiter.sv
// Scoreboard bench for wb_rw_arbiter: forwarded requests and master responses are
// popped from expectation queues by a negedge monitor; directed checks cover stalls.
module tb_wb_rw_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
        logic [3:0]  sel;
    } req_t;

    typedef struct {
        int          master;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  m_cyc, m_stb, m_we, m_ack, m_stall, m_err;
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_sel   [2];
    logic [31:0] m_rdata [2];
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_addr, s_wdata, s_data;
    logic [3:0]  s_sel;
    logic        s_ack, s_stall, s_err;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   w, l;
    int   rr_exp [4];

    wb_rw_arbiter #(.XLEN(32), .MAX_OUTSTANDING(4)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]),
        .i_m0_addr(m_addr[0]), .i_m0_data(m_wdata[0]), .i_m0_sel(m_sel[0]),
        .o_m0_data(m_rdata[0]), .o_m0_ack(m_ack[0]), .o_m0_stall(m_stall[0]), .o_m0_err(m_err[0]),
        .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]),
        .i_m1_addr(m_addr[1]), .i_m1_data(m_wdata[1]), .i_m1_sel(m_sel[1]),
        .o_m1_data(m_rdata[1]), .o_m1_ack(m_ack[1]), .o_m1_stall(m_stall[1]), .o_m1_err(m_err[1]),
        .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we),
        .o_s_addr(s_addr), .o_s_data(s_wdata), .o_s_sel(s_sel),
        .i_s_data(s_data), .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_err(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int m, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [3:0] sel);
        req_t r;
        m_stb[m] = 1'b1; m_we[m] = we; m_addr[m] = addr; m_wdata[m] = wdata; m_sel[m] = sel;
        r.addr = addr; r.we = we; r.data = wdata; r.sel = sel;
        exp_req.push_back(r);
    endtask

    task automatic expect_rsp(input int m, input logic [31:0] data, input logic err);
        rsp_t r;
        r.master = m; r.data = data; r.err = err;
        exp_rsp.push_back(r);
    endtask

    // Monitor: every accepted slave STB and every master ACK/ERR must match a queued expectation.
    always @(negedge clk) begin
        if (s_stb && !s_stall) begin
            if (exp_req.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL unexpected_stb: got addr %h expected no request", s_addr);
            end else begin
                req_t e;
                e = exp_req.pop_front();
                chk("req_addr", s_addr, e.addr);
                chk("req_we", {31'b0, s_we}, {31'b0, e.we});
                chk("req_sel", {28'b0, s_sel}, {28'b0, e.sel});
                if (e.we) chk("req_wdata", s_wdata, e.data);
            end
        end
        for (int m = 0; m < 2; m++) begin
            if (m_ack[m] || m_err[m]) begin
                if (exp_rsp.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_rsp: got response on master %0d expected none", m);
                end else begin
                    rsp_t e;
                    e = exp_rsp.pop_front();
                    chk("rsp_master", m, e.master);
                    chk("rsp_data", m_rdata[m], e.data);
                    chk("rsp_err", {31'b0, m_err[m]}, {31'b0, e.err});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef WB_RW_ARB_ROUND_ROBIN_EN
        w = 1; l = 0;
        rr_exp = '{1, 0, 1, 0};
`else
        w = 0; l = 1;
        rr_exp = '{0, 0, 0, 0};
`endif
        m_cyc = '0; m_stb = '0; m_we = '0;
        for (int m = 0; m < 2; m++) begin
            m_addr[m] = '0; m_wdata[m] = '0; m_sel[m] = '0;
        end
        s_data = '0; s_ack = 0; s_stall = 0; s_err = 0;

        // Reset held with master 0 requesting
        rst_n = 0; m_cyc[0] = 1; m_addr[0] = 32'hFFFF_0000;
        repeat (3) begin
            @(negedge clk);
            chk("rst_s_cyc", s_cyc, 0);
            chk("rst_s_addr", s_addr, 0);
            chk("rst_m0_stall", m_stall[0], 1);
            chk("rst_m1_stall", m_stall[1], 1);
        end
        cyc(); rst_n = 1;
        @(negedge clk); chk("arb_latency_s_cyc", s_cyc, 0);

        // Single read from master 0
        cyc();
        issue(0, 32'h100, 0, 0, 4'hF);
        @(negedge clk);
        chk("own0_s_cyc", s_cyc, 1);
        chk("own0_m1_stall", m_stall[1], 1);
        cyc(); m_stb[0] = 0;
        cyc(); s_ack = 1; s_data = 32'hDEADBEEF; expect_rsp(0, 32'hDEADBEEF, 0);
        cyc(); s_ack = 0; s_data = 0; m_cyc[0] = 0;

        // Contention
        cyc(); m_cyc = 2'b11;
        @(negedge clk);
        chk("cont_idle_m0_stall", m_stall[0], 1);
        chk("cont_idle_m1_stall", m_stall[1], 1);
        cyc();
        issue(w, 32'h200, 1, 32'h1111_2222, 4'h3);
        @(negedge clk);
        chk("cont_winner_stall", m_stall[w], 0);
        chk("cont_loser_stall", m_stall[l], 1);
        cyc(); m_stb[w] = 0; s_ack = 1; expect_rsp(w, 0, 0);
        @(negedge clk); chk("cont_loser_stall_ack", m_stall[l], 1);
        cyc(); s_ack = 0; m_cyc[w] = 0;
        @(negedge clk); chk("cont_loser_stall_drop", m_stall[l], 1);
        cyc();
        @(negedge clk);
        chk("cont_idle_gap_stall", m_stall[l], 1);
        chk("cont_idle_gap_cyc", s_cyc, 0);
        cyc();
        @(negedge clk);
        chk("cont_loser_granted", m_stall[l], 0);
        chk("cont_loser_s_cyc", s_cyc, 1);
        cyc(); m_cyc[l] = 0;
        cyc();

        // Outstanding limit
        m_cyc[0] = 1;
        cyc();
        for (int k = 0; k < 4; k++) begin
            issue(0, 32'h300 + 32'(4 * k), 0, 0, 4'hF);
            @(negedge clk); chk("full_fill_stall", m_stall[0], 0);
            cyc();
        end
        issue(0, 32'h310, 0, 0, 4'hF);
        @(negedge clk);
        chk("full_s_stb", s_stb, 0);
        chk("full_m0_stall", m_stall[0], 1);
        cyc(); s_ack = 1; s_data = 32'hA0; expect_rsp(0, 32'hA0, 0);
        @(negedge clk); chk("full_ack_cycle_s_stb", s_stb, 0);
        cyc(); s_ack = 0; s_data = 0;
        @(negedge clk);
        chk("full_drain_s_stb", s_stb, 1);
        chk("full_drain_stall", m_stall[0], 0);
        cyc(); m_stb[0] = 0; m_cyc[0] = 0;
        cyc();

        // Abort with two reads outstanding; late acks must be dropped
        m_cyc[1] = 1;
        cyc();
        issue(1, 32'h400, 0, 0, 4'hF);
        cyc();
        issue(1, 32'h404, 0, 0, 4'hF);
        cyc(); m_stb[1] = 0; m_cyc[1] = 0;
        @(negedge clk); chk("abort_s_cyc", s_cyc, 0);
        cyc();
        repeat (2) begin
            s_ack = 1; s_data = 32'hBAD;
            @(negedge clk);
            chk("abort_m0_ack", m_ack[0], 0);
            chk("abort_m1_ack", m_ack[1], 0);
            cyc();
        end
        s_ack = 0; s_data = 0;

        // Slave error blocks further STBs until CYC drops
        m_cyc[0] = 1;
        cyc();
        issue(0, 32'h500, 1, 32'hCAFE_0000, 4'hF);
        cyc(); m_stb[0] = 0; s_err = 1; expect_rsp(0, 0, 1);
        cyc(); s_err = 0; m_stb[0] = 1; m_we[0] = 0; m_addr[0] = 32'h508;
        @(negedge clk);
        chk("err_block_s_stb", s_stb, 0);
        chk("err_block_stall", m_stall[0], 1);
        cyc(); m_stb[0] = 0; m_cyc[0] = 0;
        cyc(); m_cyc[0] = 1;
        cyc();
        issue(0, 32'h50C, 0, 0, 4'hF);
        @(negedge clk); chk("err_recover_stall", m_stall[0], 0);
        cyc(); m_stb[0] = 0; s_ack = 1; s_data = 32'h5A5A; expect_rsp(0, 32'h5A5A, 0);
        cyc(); s_ack = 0; s_data = 0; m_cyc[0] = 0;
        cyc();

        // Both masters requesting continuously, one transfer per grant
        m_cyc = 2'b11;
        cyc();
        for (int it = 0; it < 4; it++) begin
            int g;
            g = rr_exp[it];
            issue(g, 32'h600 + 32'(4 * it), 1, 32'(it), 4'hF);
            @(negedge clk);
            chk("rr_owner_stall", m_stall[g], 0);
            chk("rr_other_stall", m_stall[1 - g], 1);
            cyc(); m_stb[g] = 0; s_ack = 1; expect_rsp(g, 0, 0);
            cyc(); s_ack = 0; m_cyc[g] = 0;
            cyc(); m_cyc[g] = 1;
            cyc();
        end
        m_cyc = '0;
        cyc(); cyc();

        chk("req_queue_empty", exp_req.size(), 0);
        chk("rsp_queue_empty", exp_rsp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
